fir_coeff_loader: RTL and testbench
===================================

// Module: fir_coeff_loader
// PURPOSE
//   Writer side of the FIR weight interface: loads a new coefficient set word by word into a shadow bank.
//   On request it commits the set atomically to the active bank that drives every tap's iv_weight.
//   Sits between the control/host stream and the transposed FIR tap chain.
//   Lets the filter keep running on the old set until the swap point.
// PARAMETERS
//   DATA_WIDTH  32  coefficient width, Q1.(DATA_WIDTH-1) signed, identical to tap weight width
//   NUM_TAPS    16  number of taps/coefficient slots, >=2; cnt width = $clog2(NUM_TAPS+1)
// PORTS
//   i_clk          in   1                    rising-edge clock
//   i_rst_n        in   1                    async active-low reset
//   i_start        in   1                    pulse: begin load sequence (honoured in IDLE only)
//   i_abort        in   1                    discard load in progress, return to IDLE
//   iv_coeff       in   DATA_WIDTH           coefficient word, slot order h[0] first
//   i_coeff_valid  in   1                    iv_coeff valid
//   o_coeff_ready  out  1                    loader accepts iv_coeff (LOAD state only)
//   i_swap_allow   in   1                    filter at safe boundary; commit permitted this cycle
//   ov_weights     out  NUM_TAPS*DATA_WIDTH  active bank, slot k at [k*DATA_WIDTH +: DATA_WIDTH] -> tap k iv_weight
//   o_busy         out  1                    high in LOAD or WAIT_SWAP
//   o_swap_done    out  1                    1-cycle pulse, first cycle new weights visible
//   ov_count       out  $clog2(NUM_TAPS+1)   words accepted in current load
// BEHAVIOUR
//   Reset (async, i_rst_n=0): state IDLE, active+shadow banks all 0, o_coeff_ready=0, o_busy=0, o_swap_done=0, ov_count=0.
//   FSM, all outputs registered:
//   - IDLE: i_start=1 -> LOAD, ov_count<=0. Any other input ignored.
//   - LOAD: o_coeff_ready=1. Transfer when i_coeff_valid & o_coeff_ready at posedge.
//     Each transfer writes shadow[ov_count]<=iv_coeff, ov_count+=1.
//     Transfer of final word (ov_count==LOAD_WORDS-1) -> WAIT_SWAP, so ready drops next cycle.
//   - WAIT_SWAP: i_swap_allow=1 -> active<=shadow at that edge, o_swap_done=1 for the following cycle, -> IDLE.
//   - LOAD_WORDS = NUM_TAPS (see CONFIGURATION).
//   - Back-to-back: one transfer per cycle sustained; valid may drop mid-load without penalty.
//   - i_abort in LOAD or WAIT_SWAP -> IDLE next cycle; shadow contents undefined, active bank unchanged, no o_swap_done.
//   - Same-cycle conflicts: abort beats coeff transfer (word dropped) and beats swap_allow.
//     i_start outside IDLE is ignored, not queued.
//   - i_swap_allow outside WAIT_SWAP has no effect.
//   - Active bank changes only on commit; never partially updated. No arithmetic on coefficients: bits pass unchanged.
//   - Swap latency: commit edge -> ov_weights valid same edge; minimum start-to-done = LOAD_WORDS+2 cycles.
// CONFIGURATION
//   COEFF_SYMMETRIC_EN defined:
//     - linear-phase mode, LOAD_WORDS = ceil(NUM_TAPS/2).
//     - Word j writes shadow[j] and shadow[NUM_TAPS-1-j]; odd NUM_TAPS centre slot written once.
//   COEFF_SYMMETRIC_EN undefined:
//     - LOAD_WORDS = NUM_TAPS, one slot per word, no mirroring logic present.
// TESTING (NUM_TAPS=4, DATA_WIDTH=32)
//   - Reset: drive i_rst_n=0 mid-LOAD -> all outputs 0 immediately, ov_weights=0, state IDLE after release.
//   - Full load: start, then valid every cycle with 0x00400000,0x00200000,0xFFE00000,0x00100000, swap_allow=1 in WAIT_SWAP
//     -> ov_weights slots 0..3 match in order, o_swap_done one cycle, no change before commit.
//   - Gapped valid: same words with valid toggling 1,0,1,0 -> identical result, ov_count steps 1..4, ready low after 4th.
//   - Hold in WAIT_SWAP: swap_allow low 10 cycles -> ov_weights keeps previous set, o_busy=1; then pulse -> commit.
//   - Abort: abort on 3rd word while valid=1 -> IDLE, ov_weights unchanged, no o_swap_done, ov_count reset on next start.
//   - COEFF_SYMMETRIC_EN: load 0x11,0x22 -> slots {0x11,0x22,0x22,0x11}; NUM_TAPS=5 with 0x1,0x2,0x3 -> {1,2,3,2,1}.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// fir_coeff_loader
//
// Writer side of the FIR weight interface. A new coefficient set is streamed
// in word by word (h[0] first) into a shadow bank while the filter keeps
// running on the active bank. Once the full set is loaded, the loader waits
// for the filter to signal a safe boundary (i_swap_allow) and then copies the
// whole shadow bank into the active bank in a single edge, so the taps never
// see a half-updated set. Coefficient bits pass through unchanged.
//
// Optional build macro:
//   COEFF_SYMMETRIC_EN - linear-phase mode. Only ceil(NUM_TAPS/2) words are
//                        loaded; word j lands in slot j and slot NUM_TAPS-1-j
//                        (an odd centre slot is written once).
//
// Parameters:
//   DATA_WIDTH  coefficient width, signed Q1.(DATA_WIDTH-1)
//   NUM_TAPS    number of coefficient slots (>= 2)
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_start        begin a load sequence (honoured only when idle)
//   i_abort        drop the load in progress, return to idle
//   iv_coeff       coefficient word
//   i_coeff_valid  iv_coeff valid
//   o_coeff_ready  loader accepts iv_coeff (LOAD state only)
//   i_swap_allow   filter is at a safe boundary, commit permitted
//   ov_weights     active bank, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_busy         high while loading or waiting for the swap
//   o_swap_done    one-cycle pulse, first cycle the new weights are visible
//   ov_count       words accepted in the current load
// ---------------------------------------------------------------------------
module fir_coeff_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TAPS   = 16
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_start,
    input  logic                               i_abort,
    input  logic [DATA_WIDTH-1:0]              iv_coeff,
    input  logic                               i_coeff_valid,
    output logic                               o_coeff_ready,
    input  logic                               i_swap_allow,
    output logic [NUM_TAPS*DATA_WIDTH-1:0]     ov_weights,
    output logic                               o_busy,
    output logic                               o_swap_done,
    output logic [$clog2(NUM_TAPS+1)-1:0]      ov_count
);

    localparam int CNT_W = $clog2(NUM_TAPS + 1);
    localparam int IDX_W = $clog2(NUM_TAPS);

`ifdef COEFF_SYMMETRIC_EN
    localparam int LOAD_WORDS = (NUM_TAPS + 1) / 2;
`else
    localparam int LOAD_WORDS = NUM_TAPS;
`endif

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LOAD_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_SWAP = 2'd2
    } state_t;

    state_t state;

    logic signed [DATA_WIDTH-1:0] shadow_bank [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] active_bank [NUM_TAPS];

    // The word counter never exceeds LOAD_WORDS-1 while a write is possible,
    // so its low bits are a valid slot index.
    logic [IDX_W-1:0] wr_idx;
    assign wr_idx = ov_count[IDX_W-1:0];

`ifdef COEFF_SYMMETRIC_EN
    // Mirror slot for linear-phase sets: h[N-1-j] = h[j].
    function automatic logic [IDX_W-1:0] mirror_idx(input logic [IDX_W-1:0] idx);
        mirror_idx = IDX_W'(NUM_TAPS - 1) - idx;
    endfunction
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= S_IDLE;
            o_coeff_ready <= 1'b0;
            o_busy        <= 1'b0;
            o_swap_done   <= 1'b0;
            ov_count      <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow_bank[k] <= '0;
                active_bank[k] <= '0;
            end
        end else begin
            o_swap_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state         <= S_LOAD;
                        ov_count      <= '0;
                        o_coeff_ready <= 1'b1;
                        o_busy        <= 1'b1;
                    end
                end

                S_LOAD: begin
                    // Abort wins over a transfer presented in the same cycle.
                    if (i_abort) begin
                        state         <= S_IDLE;
                        o_coeff_ready <= 1'b0;
                        o_busy        <= 1'b0;
                    end else if (i_coeff_valid && o_coeff_ready) begin
                        shadow_bank[wr_idx] <= iv_coeff;
`ifdef COEFF_SYMMETRIC_EN
                        shadow_bank[mirror_idx(wr_idx)] <= iv_coeff;
`endif
                        ov_count <= ov_count + 1'b1;
                        if (ov_count == LAST_WORD) begin
                            state         <= S_WAIT_SWAP;
                            o_coeff_ready <= 1'b0;
                        end
                    end
                end

                S_WAIT_SWAP: begin
                    // Abort also wins over a coincident swap permission.
                    if (i_abort) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end else if (i_swap_allow) begin
                        for (int k = 0; k < NUM_TAPS; k++) begin
                            active_bank[k] <= shadow_bank[k];
                        end
                        o_swap_done <= 1'b1;
                        o_busy      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state         <= S_IDLE;
                    o_coeff_ready <= 1'b0;
                    o_busy        <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_pack
        assign ov_weights[k*DATA_WIDTH +: DATA_WIDTH] = active_bank[k];
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;

    localparam int DW = 32;
    localparam int NT = 4;
    localparam int CW = 3;
    localparam int WW = NT * DW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort_i;
    logic [DW-1:0] coeff;
    logic          valid;
    logic          ready;
    logic          swap_allow;
    logic [WW-1:0] weights;
    logic          busy;
    logic          swap_done;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;

    fir_coeff_loader #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_abort       (abort_i),
        .iv_coeff      (coeff),
        .i_coeff_valid (valid),
        .o_coeff_ready (ready),
        .i_swap_allow  (swap_allow),
        .ov_weights    (weights),
        .o_busy        (busy),
        .o_swap_done   (swap_done),
        .ov_count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [DW-1:0] A0 = 32'h0040_0000;
    localparam logic [DW-1:0] A1 = 32'h0020_0000;
    localparam logic [DW-1:0] A2 = 32'hFFE0_0000;
    localparam logic [DW-1:0] A3 = 32'h0010_0000;
    localparam logic [WW-1:0] SET_A = {A3, A2, A1, A0};
    localparam logic [WW-1:0] SET_B = {32'h4444_4444, 32'h8333_3333, 32'h2222_2222, 32'h1111_1111};

    typedef struct packed {
        logic          st;
        logic          ab;
        logic          vl;
        logic [DW-1:0] cf;
        logic          sw;
        logic          e_ready;
        logic          e_busy;
        logic          e_done;
        logic [CW-1:0] e_cnt;
        logic [WW-1:0] e_w;
    } vec_t;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic ab, input logic vl,
                        input logic [DW-1:0] cf, input logic sw);
        start      = st;
        abort_i    = ab;
        valid      = vl;
        coeff      = cf;
        swap_allow = sw;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic e_ready, input logic e_busy,
                              input logic e_done);
        check({tag, ".ready"}, WW'(ready),     WW'(e_ready));
        check({tag, ".busy"},  WW'(busy),      WW'(e_busy));
        check({tag, ".done"},  WW'(swap_done), WW'(e_done));
    endtask

    function automatic vec_t mk(input logic st, input logic ab, input logic vl,
                                input logic [DW-1:0] cf, input logic sw,
                                input logic r, input logic b, input logic d,
                                input logic [CW-1:0] c, input logic [WW-1:0] w);
        vec_t v;
        v.st = st; v.ab = ab; v.vl = vl; v.cf = cf; v.sw = sw;
        v.e_ready = r; v.e_busy = b; v.e_done = d; v.e_cnt = c; v.e_w = w;
        return v;
    endfunction

`ifndef COEFF_SYMMETRIC_EN
    vec_t tbl [18];
    logic [DW-1:0] b_words [4];
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; abort_i = 1'b0; valid = 1'b0;
        coeff = '0; swap_allow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_ctrl("reset", 1'b0, 1'b0, 1'b0);
        check("reset.count",   WW'(count), '0);
        check("reset.weights", weights,    '0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef COEFF_SYMMETRIC_EN
        // Back-to-back load of set A, then commit.
        tbl[0]  = mk(1, 0, 0, '0, 0, 1, 1, 0, 3'd0, '0);
        tbl[1]  = mk(0, 0, 1, A0, 0, 1, 1, 0, 3'd1, '0);
        tbl[2]  = mk(0, 0, 1, A1, 0, 1, 1, 0, 3'd2, '0);
        tbl[3]  = mk(0, 0, 1, A2, 0, 1, 1, 0, 3'd3, '0);
        tbl[4]  = mk(0, 0, 1, A3, 0, 0, 1, 0, 3'd4, '0);
        tbl[5]  = mk(0, 0, 0, '0, 1, 0, 0, 1, 3'd4, SET_A);
        tbl[6]  = mk(0, 0, 0, '0, 0, 0, 0, 0, 3'd4, SET_A);
        // Gapped valid, with a stray swap_allow and start during LOAD ignored.
        tbl[7]  = mk(1, 0, 0, '0, 0, 1, 1, 0, 3'd0, SET_A);
        tbl[8]  = mk(0, 0, 1, A0, 0, 1, 1, 0, 3'd1, SET_A);
        tbl[9]  = mk(0, 0, 0, '1, 1, 1, 1, 0, 3'd1, SET_A);
        tbl[10] = mk(1, 0, 1, A1, 0, 1, 1, 0, 3'd2, SET_A);
        tbl[11] = mk(0, 0, 0, '1, 0, 1, 1, 0, 3'd2, SET_A);
        tbl[12] = mk(0, 0, 1, A2, 0, 1, 1, 0, 3'd3, SET_A);
        tbl[13] = mk(0, 0, 0, '1, 0, 1, 1, 0, 3'd3, SET_A);
        tbl[14] = mk(0, 0, 1, A3, 0, 0, 1, 0, 3'd4, SET_A);
        tbl[15] = mk(0, 0, 1, '1, 0, 0, 1, 0, 3'd4, SET_A);
        tbl[16] = mk(0, 0, 0, '0, 1, 0, 0, 1, 3'd4, SET_A);
        tbl[17] = mk(0, 0, 0, '0, 0, 0, 0, 0, 3'd4, SET_A);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].st, tbl[i].ab, tbl[i].vl, tbl[i].cf, tbl[i].sw);
            check($sformatf("vec%0d.ready", i), WW'(ready),     WW'(tbl[i].e_ready));
            check($sformatf("vec%0d.busy", i),  WW'(busy),      WW'(tbl[i].e_busy));
            check($sformatf("vec%0d.done", i),  WW'(swap_done), WW'(tbl[i].e_done));
            check($sformatf("vec%0d.count", i), WW'(count),     WW'(tbl[i].e_cnt));
            check($sformatf("vec%0d.w", i),     weights,        tbl[i].e_w);
        end

        // Hold in WAIT_SWAP: set B loaded, no commit for 10 cycles.
        b_words[0] = 32'h1111_1111; b_words[1] = 32'h2222_2222;
        b_words[2] = 32'h8333_3333; b_words[3] = 32'h4444_4444;
        step(1, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, b_words[i], 0);
        check("holdB.count", WW'(count), WW'(3'd4));
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, '0, 0);
            check($sformatf("hold%0d.busy", i), WW'(busy), WW'(1'b1));
            check($sformatf("hold%0d.w", i),    weights,   SET_A);
        end
        step(0, 0, 0, '0, 1);
        check_ctrl("commitB", 1'b0, 1'b0, 1'b1);
        check("commitB.w", weights, SET_B);
        step(0, 0, 0, '0, 0);
        check("commitB.done_clear", WW'(swap_done), '0);

        // Abort on the 3rd word while valid is high.
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, A0, 0);
        step(0, 0, 1, A1, 0);
        step(0, 1, 1, A2, 0);
        check_ctrl("abortL", 1'b0, 1'b0, 1'b0);
        check("abortL.w", weights, SET_B);
        step(0, 0, 1, A3, 1);
        check_ctrl("abortL.idle", 1'b0, 1'b0, 1'b0);
        check("abortL.idle_count", WW'(count), WW'(3'd2));
        step(1, 0, 0, '0, 0);
        check("abortL.restart_count", WW'(count), '0);
        check("abortL.restart_ready", WW'(ready), WW'(1'b1));

        // Abort beats a coincident swap_allow in WAIT_SWAP.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 32'hDEAD_0000 + DW'(i), 0);
        step(0, 1, 0, '0, 1);
        check_ctrl("abortW", 1'b0, 1'b0, 1'b0);
        check("abortW.w", weights, SET_B);
        step(0, 0, 0, '0, 1);
        check_ctrl("abortW.after", 1'b0, 1'b0, 1'b0);
        check("abortW.after_w", weights, SET_B);

        // Asynchronous reset in the middle of a load.
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, A0, 0);
        step(0, 0, 1, A1, 0);
        rst_n = 1'b0;
        #1;
        check_ctrl("rstLoad", 1'b0, 1'b0, 1'b0);
        check("rstLoad.count", WW'(count), '0);
        check("rstLoad.w",     weights,    '0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1, A2, 1);
        check_ctrl("rstLoad.idle", 1'b0, 1'b0, 1'b0);
        check("rstLoad.idle_count", WW'(count), '0);
        check("rstLoad.idle_w",     weights,    '0);
`else
        // Linear-phase mode: two words fill all four slots.
        step(1, 0, 0, '0, 0);
        check("sym.count0", WW'(count), '0);
        step(0, 0, 1, 32'h11, 0);
        check("sym.count1", WW'(count), WW'(3'd1));
        check("sym.ready1", WW'(ready), WW'(1'b1));
        step(0, 0, 1, 32'h22, 0);
        check("sym.count2", WW'(count), WW'(3'd2));
        check("sym.ready2", WW'(ready), WW'(1'b0));
        check("sym.pre_w",  weights,    '0);
        step(0, 0, 0, '0, 1);
        check_ctrl("sym.commit", 1'b0, 1'b0, 1'b1);
        check("sym.w", weights, {32'h11, 32'h22, 32'h22, 32'h11});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
